// File: rtl/retire_controller_pkg.sv
// Shared definitions for the retire controller slice.
// - Default datapath widths and FIFO/counter sizing.
// - Encodings of the commit/flush state machine.
package retire_controller_pkg;

  localparam int PHYS_W_DEF      = 6;   // physical register index width
  localparam int ARCH_W_DEF      = 5;   // architectural register index width
  localparam int DATA_W_DEF      = 32;  // result data width
  localparam int FREEQ_DEPTH_DEF = 4;   // free-return FIFO entries
  localparam int CNT_W_DEF       = 16;  // retired-instruction counter width

  typedef enum logic {
    RETIRE_RUN   = 1'b0,
    RETIRE_FLUSH = 1'b1
  } retire_state_e;

endpackage

// File: rtl/retire_controller_if.sv
// Bundle of the ROB-head, reg-file, free-list and flush signals around the
// retire controller.
// - slave  : the retire controller (consumes ROB head, drives commits).
// - master : the surrounding pipeline (ROB, reg file, free list).
interface retire_controller_if
  import retire_controller_pkg::*;
#(
  parameter int PHYS_W = PHYS_W_DEF,
  parameter int ARCH_W = ARCH_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  // ROB head
  logic              rob_head_valid;
  logic              rob_head_ready;
  logic              rob_head_regwrite;
  logic              rob_head_except;
  logic [ARCH_W-1:0] rob_head_arch_rd;
  logic [PHYS_W-1:0] rob_head_old_phys;
  logic [DATA_W-1:0] rob_head_value;
  logic              rob_pop;
  // external flush
  logic              flush_req;
  logic              flush_out;
  // architectural reg-file write port
  logic              rf_we;
  logic [ARCH_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  // physical register return to the free list
  logic              fl_ret_valid;
  logic              fl_ret_ready;
  logic [PHYS_W-1:0] fl_ret_reg;
  // statistics
  logic [CNT_W-1:0]  retire_count;

  modport slave (
    input  rob_head_valid, rob_head_ready, rob_head_regwrite, rob_head_except,
           rob_head_arch_rd, rob_head_old_phys, rob_head_value,
           flush_req, fl_ret_ready,
    output rob_pop, rf_we, rf_waddr, rf_wdata, fl_ret_valid, fl_ret_reg,
           flush_out, retire_count
  );

  modport master (
    output rob_head_valid, rob_head_ready, rob_head_regwrite, rob_head_except,
           rob_head_arch_rd, rob_head_old_phys, rob_head_value,
           flush_req, fl_ret_ready,
    input  rob_pop, rf_we, rf_waddr, rf_wdata, fl_ret_valid, fl_ret_reg,
           flush_out, retire_count
  );

endinterface

// File: rtl/retire_controller_free_return_fifo.sv
// free_return_fifo: synchronous FIFO holding freed physical registers until
// the free list accepts them.
// - push/push_data : enqueue (caller guarantees space or a same-cycle pop)
// - valid/head     : oldest entry toward the consumer
// - pop_ready      : consumer accepts head; pop = valid & pop_ready
// - full/count     : occupancy status
module free_return_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop;

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];
  assign pop   = valid & pop_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;   // idle, or push+pop (legal even when full)
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so
  // stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/retire_controller.sv
// retire_controller: in-order commit sequencer at the ROB head.
// - clk, reset (async, active-high)
// - bus (slave): ROB head in, rob_pop / reg-file write / free-list return /
//   flush pulse / retire counter out.
// At most one instruction commits per cycle. Freed physical registers are
// queued in a small FIFO so free-list back-pressure only stalls commits when
// that FIFO is full. Exceptions and external flushes enter FLUSH, which waits
// for the FIFO to drain before returning to RUN.
module retire_controller
  import retire_controller_pkg::*;
#(
  parameter int PHYS_W      = PHYS_W_DEF,
  parameter int ARCH_W      = ARCH_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FREEQ_DEPTH = FREEQ_DEPTH_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  retire_controller_if.slave   bus
);
  localparam int FCNT_W = $clog2(FREEQ_DEPTH) + 1;

  retire_state_e     state, state_nxt;
  logic              flush_nxt;
  logic              pop_c, commit;
  logic              head_done, writes_rd;
  logic              fifo_valid, fifo_full, fifo_push, fifo_pop;
  logic [PHYS_W-1:0] fifo_head;
  logic [FCNT_W-1:0] fifo_cnt;

  assign head_done = bus.rob_head_valid & bus.rob_head_ready;
  assign writes_rd = bus.rob_head_regwrite & (bus.rob_head_arch_rd != '0);
  assign fifo_pop  = fifo_valid & bus.fl_ret_ready;
  // Physical register 0 is hard-wired and never returned to the free list.
  assign fifo_push = commit & writes_rd & (bus.rob_head_old_phys != '0);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    flush_nxt = 1'b0;
    pop_c     = 1'b0;
    commit    = 1'b0;
    case (state)
      RETIRE_RUN: begin
        if (head_done & bus.rob_head_except) begin
          // Exception wins over a simultaneous flush_req: one pulse total.
          pop_c     = 1'b1;
          flush_nxt = 1'b1;
          state_nxt = RETIRE_FLUSH;
        end else if (bus.flush_req) begin
          flush_nxt = 1'b1;
          state_nxt = RETIRE_FLUSH;
        end else if (head_done & (~fifo_full | fifo_pop)) begin
          // A full FIFO stalls every commit, even ones that free nothing.
          commit = 1'b1;
          pop_c  = 1'b1;
        end
      end
      RETIRE_FLUSH: begin
        if (fifo_cnt == '0) state_nxt = RETIRE_RUN;
      end
      default: state_nxt = RETIRE_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= RETIRE_RUN;
      bus.flush_out    <= 1'b0;
      bus.retire_count <= '0;
    end else begin
      state         <= state_nxt;
      bus.flush_out <= flush_nxt;
      if (commit) bus.retire_count <= bus.retire_count + CNT_W'(1);
    end
  end

  // Combinational outputs are forced low while reset is asserted, since the
  // ROB head inputs may still look committable during that window.
  assign bus.rob_pop      = pop_c & ~reset;
  assign bus.rf_we        = commit & writes_rd & ~reset;
  assign bus.rf_waddr     = (commit & ~reset) ? bus.rob_head_arch_rd : '0;
  assign bus.rf_wdata     = (commit & ~reset) ? bus.rob_head_value   : '0;
  assign bus.fl_ret_valid = fifo_valid & ~reset;
  assign bus.fl_ret_reg   = reset ? '0 : fifo_head;

  free_return_fifo #(
    .WIDTH (PHYS_W),
    .DEPTH (FREEQ_DEPTH)
  ) u_free_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.rob_head_old_phys),
    .pop_ready (bus.fl_ret_ready),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .full      (fifo_full),
    .count     (fifo_cnt)
  );

endmodule
